// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - byte-serial framed program loader feeding the mips_pipe instruction/data memory
//
// Frame: A5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT x 4 data bytes (big-endian words), CSUM.
// CSUM is the XOR of every byte after the sync byte. A good frame releases the CPU.
//
// Ports:
//   clk1      in   pipeline first-phase clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   in_data carries a byte
//   in_data   in   stream byte
//   in_ready  out  loader accepts a byte (transfer on in_valid && in_ready)
//   mem_we    out  one-cycle memory write strobe
//   mem_addr  out  memory word address, wraps modulo 2^ADDR_W
//   mem_wdata out  32-bit word to write
//   busy      out  frame in progress (header, data or checksum phase)
//   done      out  one-cycle pulse when the checksum matches
//   err       out  sticky error, cleared only by rst
//   cpu_run   out  level release for the processor, held until rst

module mips_prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]        byte_cnt;
    logic [15:0]       word_idx;
    logic [ADDR_W-1:0] base_lo;
    logic [15:0]       count;
    logic [23:0]       shreg;
    logic [7:0]        xsum;

    logic              accept;
    logic              last_byte;
    logic [31:0]       word_full;
    logic [15:0]       hdr_base;
    logic [15:0]       hdr_count;
    logic              base_bad;
    logic              last_word;

    // Status outputs are pure decodes of the state so in_ready drops in the
    // very cycle RUN or ERR is entered.
    assign in_ready = (state == S_IDLE) || (state == S_HDR) ||
                      (state == S_DATA) || (state == S_CSUM);
    assign busy     = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign err      = (state == S_ERR);
    assign cpu_run  = (state == S_RUN);

    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt == 2'd3);

    // The shift register holds the three previous bytes, so together with the
    // current byte it forms either a full data word or the full header.
    assign word_full = {shreg, in_data};
    assign hdr_base  = shreg[23:8];
    assign hdr_count = {shreg[7:0], in_data};
    assign base_bad  = (hdr_base >> ADDR_W) != 16'd0;
    assign last_word = (word_idx + 16'd1) == count;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && (in_data == 8'hA5)) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (accept && last_byte) begin
                    if (base_bad) begin
                        state_next = S_ERR;
                    end else if (hdr_count == 16'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && last_byte && last_word) begin
                    state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == xsum) ? S_RUN : S_ERR;
                end
            end
            S_RUN:   state_next = S_RUN;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_cnt  <= 2'd0;
            word_idx  <= 16'd0;
            base_lo   <= '0;
            count     <= 16'd0;
            shreg     <= 24'd0;
            xsum      <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            done      <= 1'b0;
        end else begin
            state  <= state_next;
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == 8'hA5) begin
                            byte_cnt <= 2'd0;
                            word_idx <= 16'd0;
                            xsum     <= 8'd0;
                        end
                    end
                    S_HDR: begin
                        // byte_cnt wraps back to 0 on the 4th byte, ready for data
                        shreg    <= word_full[23:0];
                        xsum     <= xsum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            base_lo <= hdr_base[ADDR_W-1:0];
                            count   <= hdr_count;
                        end
                    end
                    S_DATA: begin
                        shreg    <= word_full[23:0];
                        xsum     <= xsum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            // address truncation to ADDR_W bits gives the wrap
                            mem_we    <= 1'b1;
                            mem_wdata <= word_full;
                            mem_addr  <= base_lo + word_idx[ADDR_W-1:0];
                            word_idx  <= word_idx + 16'd1;
                        end
                    end
                    S_CSUM: begin
                        if (in_data == xsum) begin
                            done <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - scoreboard bench for mips_prog_loader

module tb_mips_prog_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic          cpu_run;

    mips_prog_loader #(.ADDR_W(AW)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_run   (cpu_run)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail = 0;
    wr_t         exp_q[$];
    int          ev_q[$];     // 1 = done pulse, 2 = err rise
    logic [31:0] prog[$];
    logic [7:0]  frame[$];
    bit          gap_en = 1'b0;
    bit          exp_ok = 1'b0;
    bit          err_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes and terminal events as the DUT presents them.
    always @(negedge clk1) begin
        wr_t w;
        if (mem_we) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(w.addr));
                check("wr_data", mem_wdata, w.data);
            end
        end
        if (done) begin
            check("done_expected", 32'((ev_q.size() > 0) ? ev_q[0] : 0), 32'd1);
            if (ev_q.size() > 0) void'(ev_q.pop_front());
        end
        if (err && !err_prev) begin
            check("err_expected", 32'((ev_q.size() > 0) ? ev_q[0] : 0), 32'd2);
            if (ev_q.size() > 0) void'(ev_q.pop_front());
        end
        err_prev = err;
    end

    // Reference model: builds the byte frame from fields and predicts the
    // resulting memory writes and terminal outcome.
    task automatic build_frame(input logic [15:0] base, input logic [15:0] cnt, input bit bad);
        logic [7:0] x;
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(base[15:8]);
        frame.push_back(base[7:0]);
        frame.push_back(cnt[15:8]);
        frame.push_back(cnt[7:0]);
        for (int i = 0; i < int'(cnt); i++) begin
            for (int b = 3; b >= 0; b--) frame.push_back(8'((prog[i] >> (8 * b)) & 32'hFF));
        end
        x = 8'd0;
        for (int i = 1; i < frame.size(); i++) x = x ^ frame[i];
        frame.push_back(bad ? (x ^ 8'h01) : x);
        if (int'(base) >= DEPTH) begin
            exp_ok = 1'b0;
            ev_q.push_back(2);
        end else begin
            for (int i = 0; i < int'(cnt); i++)
                exp_q.push_back('{addr: AW'((int'(base) + i) % DEPTH), data: prog[i]});
            exp_ok = !bad;
            ev_q.push_back(bad ? 2 : 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        while (gap_en && (g < 8) && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            @(posedge clk1);
            #1;
            g++;
        end
        if (in_ready) begin
            in_valid = 1'b1;
            in_data  = b;
            @(posedge clk1);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    endtask

    // Asserts rst between clock edges, so the checks show asynchronous clearing.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk1);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] base, input logic [15:0] cnt, input bit bad);
        build_frame(base, cnt, bad);
        foreach (frame[i]) begin
            send_byte(frame[i]);
            if (i == 0) check("busy_after_sync", 32'(busy), 32'd1);
        end
        check("end_in_ready", 32'(in_ready), 32'd0);
        check("end_done", 32'(done), 32'(exp_ok));
        check("end_cpu_run", 32'(cpu_run), 32'(exp_ok));
        check("end_err", 32'(err), 32'(!exp_ok));
        // Bytes offered after the frame must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(posedge clk1);
        #1;
        in_valid = 1'b0;
        check("hold_cpu_run", 32'(cpu_run), 32'(exp_ok));
        check("hold_err", 32'(err), 32'(!exp_ok));
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_done", 32'(done), 32'd0);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        check("events_drained", 32'(ev_q.size()), 32'd0);
    endtask

    task automatic load_mips_program();
        prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800, 32'h2842002d,
                 32'h00222000, 32'h0c631800, 32'h24220001, 32'hfc000000};
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] b;
        int          sel;
        int          c;
        bit          bad;

        #12;
        check_reset_outputs("por");
        @(posedge clk1);
        #1;
        rst = 1'b0;

        // single word, good checksum
        prog = '{32'h28010078};
        run_frame(16'h0000, 16'd1, 1'b0);
        check("single_csum_byte", 32'(frame[frame.size()-1]), 32'h50);
        do_reset("rst1");

        // full nine-word program at base 0
        load_mips_program();
        run_frame(16'h0000, 16'd9, 1'b0);
        do_reset("rst2");

        // bad checksum: the write still happens
        prog = '{32'h28010078};
        run_frame(16'h0000, 16'd1, 1'b1);
        repeat (5) @(posedge clk1);
        #1;
        check("err_sticky", 32'(err), 32'd1);
        do_reset("rst3");

        // garbage, empty frame, back-pressure
        gap_en = 1'b1;
        send_byte(8'h00);
        check("garbage_busy0", 32'(busy), 32'd0);
        send_byte(8'hFF);
        check("garbage_busy1", 32'(busy), 32'd0);
        send_byte(8'h12);
        check("garbage_busy2", 32'(busy), 32'd0);
        prog.delete();
        run_frame(16'h0010, 16'd0, 1'b0);
        gap_en = 1'b0;
        do_reset("rst4");

        // address wrap
        prog = '{32'hDEADBEEF, 32'h01234567};
        run_frame(16'h03FF, 16'd2, 1'b0);
        do_reset("rst5");

        // base out of range
        prog = '{32'h11111111};
        run_frame(16'h0400, 16'd1, 1'b0);
        do_reset("rst6");

        // reset after six data bytes
        prog = '{32'hA1B2C3D4, 32'h55667788};
        build_frame(16'h0005, 16'd2, 1'b0);
        for (int i = 0; i < 11; i++) send_byte(frame[i]);
        check("mid_busy", 32'(busy), 32'd1);
        do_reset("rst_mid");
        check("mid_pending_writes", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        ev_q.delete();

        // reset while the write strobe is in flight
        prog = '{32'hCAFEF00D};
        build_frame(16'h0007, 16'd1, 1'b0);
        for (int i = 0; i < 9; i++) send_byte(frame[i]);
        check("inflight_we", 32'(mem_we), 32'd1);
        check("inflight_addr", 32'(mem_addr), 32'd7);
        do_reset("rst_inflight");
        exp_q.delete();
        ev_q.delete();

        // a full frame loads cleanly after the aborted ones
        load_mips_program();
        run_frame(16'h0000, 16'd9, 1'b0);
        do_reset("rst7");

        // randomized frames
        for (int t = 0; t < 12; t++) begin
            sel = $urandom_range(0, 3);
            c   = $urandom_range(0, 5);
            bad = ($urandom_range(0, 3) == 0);
            case (sel)
                0:       b = 16'($urandom_range(0, 1000));
                1:       b = 16'(1020 + $urandom_range(0, 3));
                2:       b = 16'($urandom_range(1024, 65535));
                default: b = 16'($urandom_range(0, 1023));
            endcase
            prog.delete();
            for (int k = 0; k < c; k++) prog.push_back($urandom);
            gap_en = ($urandom_range(0, 1) == 1);
            run_frame(b, 16'(c), bad);
            gap_en = 1'b0;
            do_reset("rst_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
